// File: rtl/batcharger_ctrl_if.sv
// Sample/setpoint bundle between the charger sequencer and the charge controller.
interface batcharger_ctrl_if;
  logic       en;
  logic [3:0] sel;
  logic       adc_valid;
  logic [7:0] vbat_code;
  logic [7:0] ibat_code;
  logic [7:0] vtemp_code;
  logic       tc;
  logic       cc;
  logic       cv;
  logic [7:0] iset_code;
  logic [7:0] vset_code;
  logic       done;
  logic       fault;

  modport master (
    output en, sel, adc_valid, vbat_code, ibat_code, vtemp_code,
    input  tc, cc, cv, iset_code, vset_code, done, fault
  );

  modport slave (
    input  en, sel, adc_valid, vbat_code, ibat_code, vtemp_code,
    output tc, cc, cv, iset_code, vset_code, done, fault
  );
endinterface

// File: rtl/batcharger_ctrl.sv
// Li-ion charge controller: trickle / constant-current / constant-voltage sequencing
// with debounced thresholds, CV timeout and latched temperature fault.
module batcharger_ctrl #(
  parameter logic [7:0]  VCUTOFF   = 8'd170,
  parameter logic [7:0]  VTARGET   = 8'd238,
  parameter logic [7:0]  VRECHARGE = 8'd227,
  parameter logic [7:0]  TMIN      = 8'd30,
  parameter logic [7:0]  TMAX      = 8'd200,
  parameter int unsigned DEB       = 4,
  parameter logic [15:0] CVTMAX    = 16'd50000
) (
  input  logic              clk,
  input  logic              rstz,
  batcharger_ctrl_if.slave  bus
);

  localparam int unsigned DEB_W = 4;
  localparam int unsigned CVC_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_TC, S_CC, S_CV, S_END, S_FAULT
  } state_e;

  state_e             state_q, state_d;
  logic [DEB_W-1:0]   deb_q, deb_d;
  logic [CVC_W-1:0]   cvcnt_q, cvcnt_d;
  logic               tc_q, tc_d, cc_q, cc_d, cv_q, cv_d;
  logic [7:0]         iset_q, iset_d, vset_q, vset_d;
  logic               done_q, done_d, fault_q, fault_d;

  // Capacity-derived currents, LSB 5mA: 1C, C/10 and the CV termination level.
  logic [7:0] sel_p1_c, icc_c, itc_c, icut_c;
  assign sel_p1_c = {4'd0, bus.sel} + 8'd1;
  assign icc_c    = 8'(sel_p1_c * 8'd10);
  assign itc_c    = sel_p1_c;
  assign icut_c   = sel_p1_c;

  logic             temp_ok_c;
  state_e           entry_c;
  logic             qual_c;
  state_e           tgt_c;
  logic [DEB_W-1:0] deb_inc_c;
  logic [CVC_W-1:0] cv_inc_c;

  assign temp_ok_c = (bus.vtemp_code >= TMIN) && (bus.vtemp_code <= TMAX);
  assign deb_inc_c = deb_q + DEB_W'(1);
  assign cv_inc_c  = cvcnt_q + CVC_W'(1);

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= S_IDLE;
      deb_q   <= '0;
      cvcnt_q <= '0;
      tc_q    <= 1'b0;
      cc_q    <= 1'b0;
      cv_q    <= 1'b0;
      iset_q  <= '0;
      vset_q  <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      cvcnt_q <= cvcnt_d;
      tc_q    <= tc_d;
      cc_q    <= cc_d;
      cv_q    <= cv_d;
      iset_q  <= iset_d;
      vset_q  <= vset_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  // Next state, debounce/CV counters and registered output values.
  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    cvcnt_d = cvcnt_q;
    qual_c  = 1'b0;
    tgt_c   = state_q;

    if (bus.vbat_code < VCUTOFF)       entry_c = S_TC;
    else if (bus.vbat_code >= VTARGET) entry_c = S_CV;
    else                               entry_c = S_CC;

    // Condition the debounce counter is watching in each state, and where it leads.
    unique case (state_q)
      S_TC:    begin qual_c = (bus.vbat_code >= VCUTOFF);   tgt_c = S_CC;    end
      S_CC:    begin qual_c = (bus.vbat_code >= VTARGET);   tgt_c = S_CV;    end
      S_CV:    begin qual_c = (bus.ibat_code < icut_c);     tgt_c = S_END;   end
      S_END:   begin qual_c = (bus.vbat_code < VRECHARGE);  tgt_c = entry_c; end
      S_FAULT: begin qual_c = temp_ok_c;                    tgt_c = S_IDLE;  end
      default: begin qual_c = 1'b0;                         tgt_c = state_q; end
    endcase

    if (!bus.en && (state_q != S_FAULT)) begin
      state_d = S_IDLE;
    end else if (bus.adc_valid) begin
      if (state_q == S_IDLE) begin
        if (bus.en && temp_ok_c) state_d = entry_c;
      end else if ((state_q != S_FAULT) && !temp_ok_c) begin
        state_d = S_FAULT;
      end else begin
        deb_d = qual_c ? deb_inc_c : '0;
        if (qual_c && (deb_inc_c == DEB_W'(DEB))) state_d = tgt_c;
        if (state_q == S_CV) begin
          cvcnt_d = cv_inc_c;
          if (cv_inc_c == CVTMAX) state_d = S_END;
        end
      end
    end

    if (state_d != state_q) begin
      deb_d   = '0;
      cvcnt_d = '0;
    end

    tc_d    = (state_d == S_TC);
    cc_d    = (state_d == S_CC);
    cv_d    = (state_d == S_CV);
    done_d  = (state_d == S_END);
    fault_d = (state_d == S_FAULT);
    iset_d  = '0;
    vset_d  = '0;
    unique case (state_d)
      S_TC:       begin iset_d = itc_c; vset_d = VTARGET; end
      S_CC, S_CV: begin iset_d = icc_c; vset_d = VTARGET; end
      default:    begin iset_d = '0;    vset_d = '0;      end
    endcase
  end

  assign bus.tc        = tc_q;
  assign bus.cc        = cc_q;
  assign bus.cv        = cv_q;
  assign bus.iset_code = iset_q;
  assign bus.vset_code = vset_q;
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_batcharger_ctrl.sv
// Directed bench for batcharger_ctrl: rule-level reference model compared every cycle,
// plus literal spot checks at the points the charge profile turns.
module tb_batcharger_ctrl;

  localparam int CVT = 20;
  localparam int M_IDLE = 0, M_TC = 1, M_CC = 2, M_CV = 3, M_END = 4, M_FAULT = 5;

  logic clk;
  logic rstz;
  int   checks;
  int   failures;
  logic cmp_en;

  batcharger_ctrl_if bus ();

  batcharger_ctrl #(.CVTMAX(16'(CVT))) dut (
    .clk  (clk),
    .rstz (rstz),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: charging phase, run length of the pending condition, samples in CV.
  typedef struct {
    int mode;
    int run;
    int cvn;
  } mst_t;

  mst_t       m;
  logic [3:0] m_sel;

  function automatic int pick(input int v);
    if (v < 170) return M_TC;
    if (v >= 238) return M_CV;
    return M_CC;
  endfunction

  function automatic mst_t step(input mst_t s, input logic en, input logic vld,
                                input int v, input int i, input int t, input int sel);
    mst_t r;
    int   nxt;
    bit   tok;
    bit   q;
    r   = s;
    nxt = s.mode;
    tok = (t >= 30) && (t <= 200);
    if (!en && s.mode != M_FAULT) begin
      nxt = M_IDLE;
    end else if (vld) begin
      if (s.mode == M_IDLE) begin
        if (en && tok) nxt = pick(v);
      end else if (s.mode != M_FAULT && !tok) begin
        nxt = M_FAULT;
      end else begin
        case (s.mode)
          M_TC:    q = (v >= 170);
          M_CC:    q = (v >= 238);
          M_CV:    q = (i < sel + 1);
          M_END:   q = (v < 227);
          default: q = tok;
        endcase
        r.run = q ? r.run + 1 : 0;
        if (s.mode == M_CV) r.cvn = r.cvn + 1;
        if (r.run == 4) begin
          case (s.mode)
            M_TC:    nxt = M_CC;
            M_CC:    nxt = M_CV;
            M_CV:    nxt = M_END;
            M_END:   nxt = pick(v);
            default: nxt = M_IDLE;
          endcase
        end
        if (s.mode == M_CV && r.cvn == CVT) nxt = M_END;
      end
    end
    if (nxt != s.mode) begin
      r.run = 0;
      r.cvn = 0;
    end
    r.mode = nxt;
    return r;
  endfunction

  always @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      m     <= '{M_IDLE, 0, 0};
      m_sel <= 4'd0;
    end else begin
      m     <= step(m, bus.en, bus.adc_valid, int'(bus.vbat_code), int'(bus.ibat_code),
                    int'(bus.vtemp_code), int'(bus.sel));
      m_sel <= bus.sel;
    end
  end

  function automatic logic [20:0] expected(input int mode, input logic [3:0] s);
    int   c;
    logic [7:0] iset;
    logic [7:0] vset;
    c    = int'(s) + 1;
    iset = 8'd0;
    vset = 8'd0;
    if (mode == M_TC) begin iset = 8'(c); vset = 8'd238; end
    if (mode == M_CC || mode == M_CV) begin iset = 8'(c * 10); vset = 8'd238; end
    return {mode == M_TC, mode == M_CC, mode == M_CV, iset, vset,
            mode == M_END, mode == M_FAULT};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Every cycle: whole output vector against the model, and mode one-hotness.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model", 32'({bus.tc, bus.cc, bus.cv, bus.iset_code, bus.vset_code,
                          bus.done, bus.fault}), 32'(expected(m.mode, m_sel)));
      check("onehot", 32'($onehot0({bus.cv, bus.cc, bus.tc})), 32'd1);
    end
  end

  task automatic sample(input logic [7:0] v, input logic [7:0] i, input logic [7:0] t);
    bus.vbat_code  = v;
    bus.ibat_code  = i;
    bus.vtemp_code = t;
    bus.adc_valid  = 1'b1;
    @(negedge clk);
    bus.adc_valid  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic samples(input int n, input logic [7:0] v, input logic [7:0] i,
                         input logic [7:0] t);
    for (int k = 0; k < n; k++) sample(v, i, t);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    cmp_en         = 1'b0;
    rstz           = 1'b0;
    bus.en         = 1'b0;
    bus.sel        = 4'b1000;
    bus.adc_valid  = 1'b0;
    bus.vbat_code  = 8'd0;
    bus.ibat_code  = 8'd0;
    bus.vtemp_code = 8'd100;
    repeat (2) @(negedge clk);
    check("reset_outs", 32'({bus.tc, bus.cc, bus.cv, bus.iset_code, bus.vset_code,
                             bus.done, bus.fault}), 32'd0);
    rstz   = 1'b1;
    cmp_en = 1'b1;
    bus.en = 1'b1;
    @(negedge clk);

    // Trickle below cutoff, glitch rejection, then CC on the 4th qualifying sample.
    sample(8'd150, 8'd0, 8'd100);
    check("tc_entry", 32'({bus.tc, bus.cc, bus.cv}), 32'b100);
    check("tc_iset", 32'(bus.iset_code), 32'd9);
    samples(3, 8'd175, 8'd0, 8'd100);
    sample(8'd150, 8'd0, 8'd100);
    check("glitch_hold", 32'(bus.tc), 32'd1);
    samples(3, 8'd175, 8'd0, 8'd100);
    check("tc_after3", 32'(bus.tc), 32'd1);
    sample(8'd175, 8'd0, 8'd100);
    check("cc_entry", 32'({bus.tc, bus.cc, bus.cv}), 32'b010);
    check("cc_iset", 32'(bus.iset_code), 32'd90);

    // CC -> CV -> END by termination current.
    samples(4, 8'd240, 8'd50, 8'd100);
    check("cv_entry", 32'({bus.cv, bus.vset_code}), 32'({1'b1, 8'd238}));
    samples(4, 8'd240, 8'd8, 8'd100);
    check("end_state", 32'({bus.done, bus.tc, bus.cc, bus.cv, bus.iset_code}),
          32'({1'b1, 3'b000, 8'd0}));

    // Recharge restarts into CC or TC depending on the battery voltage.
    samples(4, 8'd220, 8'd0, 8'd100);
    check("recharge_cc", 32'({bus.cc, bus.done}), 32'b10);
    samples(4, 8'd240, 8'd50, 8'd100);
    samples(4, 8'd240, 8'd8, 8'd100);
    samples(4, 8'd160, 8'd0, 8'd100);
    check("recharge_tc", 32'({bus.tc, bus.done}), 32'b10);

    // Temperature fault from CC, recovery to IDLE, then restart.
    samples(4, 8'd175, 8'd0, 8'd100);
    sample(8'd175, 8'd0, 8'd210);
    check("fault_set", 32'({bus.fault, bus.iset_code, bus.cc}), 32'({1'b1, 8'd0, 1'b0}));
    samples(3, 8'd175, 8'd0, 8'd100);
    check("fault_hold", 32'(bus.fault), 32'd1);
    sample(8'd175, 8'd0, 8'd100);
    check("fault_clear", 32'({bus.fault, bus.tc, bus.cc, bus.cv}), 32'd0);
    sample(8'd200, 8'd0, 8'd100);
    check("restart_cc", 32'(bus.cc), 32'd1);

    // CV timeout after CVT samples with current above termination.
    samples(4, 8'd240, 8'd50, 8'd100);
    samples(CVT - 1, 8'd240, 8'd50, 8'd100);
    check("cv_pre_timeout", 32'({bus.cv, bus.done}), 32'b10);
    sample(8'd240, 8'd50, 8'd100);
    check("cv_timeout", 32'({bus.cv, bus.done}), 32'b01);

    // en low clears done; sel change retargets iset; en low drops modes.
    bus.en = 1'b0;
    @(negedge clk);
    check("en_off_done", 32'(bus.done), 32'd0);
    bus.en = 1'b1;
    sample(8'd200, 8'd0, 8'd100);
    check("cc_again", 32'({bus.cc, bus.iset_code}), 32'({1'b1, 8'd90}));
    bus.sel = 4'd3;
    @(negedge clk);
    check("sel_change", 32'({bus.cc, bus.iset_code}), 32'({1'b1, 8'd40}));
    bus.en = 1'b0;
    @(negedge clk);
    check("en_off_modes", 32'({bus.tc, bus.cc, bus.cv}), 32'd0);
    bus.en = 1'b1;
    sample(8'd200, 8'd0, 8'd100);

    // Asynchronous reset between edges.
    @(posedge clk);
    #2 rstz = 1'b0;
    #1 check("async_reset", 32'({bus.tc, bus.cc, bus.cv, bus.iset_code, bus.vset_code,
                                 bus.done, bus.fault}), 32'd0);
    #1 rstz = 1'b1;
    @(negedge clk);

    // Direct CV entry, fault latched across en low, out-of-window start blocked.
    sample(8'd245, 8'd50, 8'd100);
    check("idle_to_cv", 32'({bus.cv, bus.iset_code}), 32'({1'b1, 8'd40}));
    sample(8'd245, 8'd50, 8'd20);
    check("cold_fault", 32'(bus.fault), 32'd1);
    bus.en = 1'b0;
    repeat (2) @(negedge clk);
    check("fault_latched", 32'(bus.fault), 32'd1);
    samples(4, 8'd200, 8'd0, 8'd100);
    check("fault_exit_en0", 32'(bus.fault), 32'd0);
    bus.en = 1'b1;
    sample(8'd200, 8'd0, 8'd250);
    check("hot_no_start", 32'({bus.tc, bus.cc, bus.cv}), 32'd0);
    sample(8'd100, 8'd0, 8'd100);
    check("tc_sel3", 32'({bus.tc, bus.iset_code}), 32'({1'b1, 8'd4}));

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
